six_phase_checker: RTL and testbench

Downstream consumer of the six-state code counter. It samples the counter's 3-bit state code and its registered carry each clock, decodes the code to a binary phase index, and checks every transition against the legal sequence. It acquires lock after a run of clean transitions and counts full counter cycles (carry pulses) while locked. It reports illegal transitions as pulses plus a saturating error count for the diagnostic path.

---
 rtl/six_phase_checker.sv | 164 ++++++++++++++++
 tb/tb_six_phase_checker.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/six_phase_checker.sv
// six_phase_checker: decodes the six-state code counter output, checks every
// transition against the legal code sequence, acquires lock after a run of
// clean transitions and counts full counter cycles while locked.
module six_phase_checker #(
  parameter int LOCK_N = 4,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       q_in,
  input  logic             cout_in,
  input  logic             sclr,
  output logic [2:0]       phase,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             cycle_wrap
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0]       LOCK_RUN = 4'(LOCK_N);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Binary phase index of a state code; 7 marks the two unused codes.
  function automatic logic [2:0] decode_phase(input logic [2:0] code);
    case (code)
      3'b010:  decode_phase = 3'd0;
      3'b011:  decode_phase = 3'd1;
      3'b111:  decode_phase = 3'd2;
      3'b110:  decode_phase = 3'd3;
      3'b100:  decode_phase = 3'd4;
      3'b000:  decode_phase = 3'd5;
      default: decode_phase = 3'd7;
    endcase
  endfunction

  // Code expected on the clock after the given one. Unused codes never
  // qualify a transition (their valid flag is clear), so their entry is moot.
  function automatic logic [2:0] next_code(input logic [2:0] code);
    case (code)
      3'b010:  next_code = 3'b011;
      3'b011:  next_code = 3'b111;
      3'b111:  next_code = 3'b110;
      3'b110:  next_code = 3'b100;
      3'b100:  next_code = 3'b000;
      3'b000:  next_code = 3'b010;
      default: next_code = 3'b010;
    endcase
  endfunction

  state_t     state_r, state_s;
  logic [3:0] run_r, run_s;
  logic [2:0] q_d_r;
  logic       v_d_r;
  logic       sample_ok_s;
  logic       trans_ok_s;
  logic       err_s;
  logic       count_s;

  // Qualify the current sample and the transition from the previous one.
  always_comb begin
    sample_ok_s = (decode_phase(q_in) != 3'd7) && (cout_in == (q_in == 3'b010));
    trans_ok_s  = v_d_r && sample_ok_s && (q_in == next_code(q_d_r));
    count_s     = (state_r == LOCKED) && trans_ok_s && cout_in;
  end

  // Next-state, run counter and error decision for the lock FSM.
  always_comb begin
    state_s = state_r;
    run_s   = run_r;
    err_s   = 1'b0;
    case (state_r)
      HUNT: begin
        if (sample_ok_s) begin
          state_s = CHECK;
          run_s   = 4'd0;
        end else begin
          state_s = HUNT;
        end
      end
      CHECK: begin
        if (trans_ok_s) begin
          run_s = run_r + 4'd1;
          if ((run_r + 4'd1) == LOCK_RUN) begin
            state_s = LOCKED;
          end else begin
            state_s = CHECK;
          end
        end else begin
          err_s   = 1'b1;
          state_s = HUNT;
          run_s   = 4'd0;
        end
      end
      LOCKED: begin
        if (trans_ok_s) begin
          state_s = LOCKED;
        end else begin
          err_s   = 1'b1;
          state_s = HUNT;
          run_s   = 4'd0;
        end
      end
      default: begin
        state_s = HUNT;
        run_s   = 4'd0;
      end
    endcase
  end

  // FSM state, previous-sample history and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= HUNT;
      run_r   <= 4'd0;
      q_d_r   <= 3'b000;
      v_d_r   <= 1'b0;
      phase   <= 3'd7;
      locked  <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_r <= state_s;
      run_r   <= run_s;
      q_d_r   <= q_in;
      v_d_r   <= sample_ok_s;
      phase   <= decode_phase(q_in);
      locked  <= (state_s == LOCKED);
      err     <= err_s;
    end
  end

  // Diagnostic counters; the clear wins over any increment on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt    <= 8'd0;
      cycle_cnt  <= '0;
      cycle_wrap <= 1'b0;
    end else if (sclr) begin
      err_cnt    <= 8'd0;
      cycle_cnt  <= '0;
      cycle_wrap <= 1'b0;
    end else begin
      if (err_s && (err_cnt != 8'd255)) begin
        err_cnt <= err_cnt + 8'd1;
      end else begin
        err_cnt <= err_cnt;
      end
      if (count_s) begin
        cycle_cnt  <= cycle_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        cycle_wrap <= (cycle_cnt == CNT_MAX);
      end else begin
        cycle_cnt  <= cycle_cnt;
        cycle_wrap <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_six_phase_checker.sv
// Bench for six_phase_checker: directed scenarios with literal expectations
// plus a randomized stream, all checked every cycle against a sequence model.
module tb_six_phase_checker;

  localparam int LOCK_N = 4;
  localparam int CNT_W  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] q_in = 3'b000;
  logic cout_in = 1'b0;
  logic sclr = 1'b0;
  logic [2:0] phase;
  logic locked;
  logic err;
  logic [7:0] err_cnt;
  logic [CNT_W-1:0] cycle_cnt;
  logic cycle_wrap;

  six_phase_checker #(.LOCK_N(LOCK_N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .cout_in(cout_in), .sclr(sclr),
    .phase(phase), .locked(locked), .err(err), .err_cnt(err_cnt),
    .cycle_cnt(cycle_cnt), .cycle_wrap(cycle_wrap)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic cmp_en = 1'b0;
  logic [2:0] codes [6] = '{3'b010, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};
  int pos = 0;

  // Model state: previous sample as a phase index, mode 0/1/2 = hunt/check/locked.
  int m_prev_idx = -1;
  bit m_prev_ok = 1'b0;
  int m_mode = 0;
  int m_run = 0;
  int e_phase = 7, e_locked = 0, e_err = 0, e_errcnt = 0, e_cyc = 0, e_wrap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int code_idx(input logic [2:0] c);
    for (int i = 0; i < 6; i++) if (codes[i] == c) return i;
    return -1;
  endfunction

  task automatic m_reset();
    m_prev_idx = -1; m_prev_ok = 1'b0; m_mode = 0; m_run = 0;
    e_phase = 7; e_locked = 0; e_err = 0; e_errcnt = 0; e_cyc = 0; e_wrap = 0;
  endtask

  task automatic m_step(input logic [2:0] q, input logic c, input logic s);
    int idx;
    bit ok, tr, inc;
    idx = code_idx(q);
    ok  = (idx >= 0) && (c == (idx == 0));
    tr  = m_prev_ok && ok && (idx == (m_prev_idx + 1) % 6);
    inc = (m_mode == 2) && tr && c;
    e_phase = (idx < 0) ? 7 : idx;
    e_err = 0;
    e_wrap = 0;
    if (m_mode == 0) begin
      if (ok) begin m_mode = 1; m_run = 0; end
    end else if (m_mode == 1) begin
      if (tr) begin
        m_run++;
        if (m_run == LOCK_N) m_mode = 2;
      end else begin
        e_err = 1; m_mode = 0; m_run = 0;
      end
    end else begin
      if (!tr) begin e_err = 1; m_mode = 0; m_run = 0; end
    end
    e_locked = (m_mode == 2);
    if (s) begin
      e_errcnt = 0; e_cyc = 0;
    end else begin
      if (e_err == 1 && e_errcnt < 255) e_errcnt++;
      if (inc) begin
        e_cyc = (e_cyc + 1) % (1 << CNT_W);
        e_wrap = (e_cyc == 0);
      end
    end
    m_prev_ok = ok;
    m_prev_idx = idx;
  endtask

  // Advance the model on the same events that move the design.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else m_step(q_in, cout_in, sclr);
  end

  // Compare every output against the model between active edges.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_phase", phase, e_phase);
      check("m_locked", locked, e_locked);
      check("m_err", err, e_err);
      check("m_err_cnt", err_cnt, e_errcnt);
      check("m_cycle_cnt", cycle_cnt, e_cyc);
      check("m_cycle_wrap", cycle_wrap, e_wrap);
    end
  end

  task automatic drive(input logic [2:0] q, input logic c, input logic s);
    q_in = q; cout_in = c; sclr = s;
    @(negedge clk);
  endtask

  task automatic feed(input int idx);
    drive(codes[idx], (idx == 0), 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_phase"}, phase, 7);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_cycle_cnt"}, cycle_cnt, 0);
    check({tag, "_cycle_wrap"}, cycle_wrap, 0);
  endtask

  initial begin
    int exp_cnt [4] = '{2, 3, 0, 1};
    int exp_wrap [4] = '{0, 0, 1, 0};
    int r;
    int k;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    cmp_en = 1'b1;
    rst_n = 1'b1;

    // Clean stream from 010: phases 0..5,0 and lock after the 5th edge.
    for (int i = 0; i < 7; i++) begin
      feed(i % 6);
      check("clean_phase", phase, i % 6);
      if (i == 3) check("lock_not_yet", locked, 0);
      if (i == 4) check("lock_5th_edge", locked, 1);
    end
    check("first_cycle_cnt", cycle_cnt, 1);

    // Four more full cycles: 2,3,0,1 with one wrap on 3->0.
    for (int c = 0; c < 4; c++) begin
      for (int j = 1; j <= 6; j++) feed(j % 6);
      check("cycle_cnt", cycle_cnt, exp_cnt[c]);
      check("cycle_wrap", cycle_wrap, exp_wrap[c]);
    end

    // Skip 011 -> 110 while locked, then relock 5 edges later.
    feed(1);
    drive(codes[3], 1'b0, 1'b0);
    check("skip_err", err, 1);
    check("skip_locked", locked, 0);
    check("skip_err_cnt", err_cnt, 1);
    k = 0;
    foreach (codes[j]) begin
      k++;
      if (k <= 5) begin
        feed((j + 4) % 6);
        if (k == 4) check("relock_not_yet", locked, 0);
        if (k == 5) check("relock", locked, 1);
      end
    end

    // Carry asserted on 111 while locked.
    for (int j = 3; j <= 7; j++) feed(j % 6);
    check("pre_carry_locked", locked, 1);
    drive(3'b111, 1'b1, 1'b0);
    check("carry_phase", phase, 2);
    check("carry_err", err, 1);
    check("carry_locked", locked, 0);
    feed(3);
    check("after_carry_err", err, 0);
    check("after_carry_locked", locked, 0);

    // Illegal code, then a held 010.
    drive(3'b101, 1'b0, 1'b0);
    check("illegal_phase", phase, 7);
    check("illegal_err", err, 1);
    drive(3'b010, 1'b1, 1'b0);
    check("hunt_sample_err", err, 0);
    drive(3'b010, 1'b1, 1'b0);
    check("hold_err", err, 1);
    check("hold_phase", phase, 0);

    // 300 more errors saturate the count; sclr then wins over a counted error.
    repeat (300) begin
      drive(3'b010, 1'b1, 1'b0);
      drive(3'b010, 1'b1, 1'b0);
    end
    check("sat_err_cnt", err_cnt, 255);
    drive(3'b010, 1'b1, 1'b0);
    drive(3'b010, 1'b1, 1'b1);
    check("sclr_err", err, 1);
    check("sclr_err_cnt", err_cnt, 0);

    // Randomized stream with occasional faults and clears.
    pos = 0;
    for (int n = 0; n < 2000; n++) begin
      if (n == 1500) begin
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
      end
      r = $urandom_range(0, 99);
      if (r < 80) begin pos = (pos + 1) % 6; feed(pos); end
      else if (r < 85) drive(codes[pos], (pos == 0), 1'b0);
      else if (r < 90) begin pos = (pos + 2) % 6; feed(pos); end
      else if (r < 94) drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
      else if (r < 97) begin pos = (pos + 1) % 6; drive(codes[pos], (pos != 0), 1'b0); end
      else begin pos = (pos + 1) % 6; drive(codes[pos], (pos == 0), 1'b1); end
    end
    sclr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
